// File: rtl/move_stepper.sv
// Step-pulse generator for the game-board position counters.
// Emits one D strobe per square of a move and keeps a shadow copy of every player's position.
module move_stepper #(
  parameter int unsigned TRACK    = 24,
  parameter int unsigned STEP_GAP = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       setup,
  input  logic       setup_we,
  input  logic [1:0] setup_pid,
  input  logic [4:0] setup_pos,
  input  logic       start,
  input  logic [1:0] pid,
  input  logic [2:0] steps,
  output logic       D,
  output logic [3:0] p_da,
  output logic       busy,
  output logic       done,
  output logic [4:0] cur_pos
);

  localparam int unsigned POS_W   = 5;
  localparam int unsigned PID_W   = 2;
  localparam int unsigned STEP_W  = 3;
  localparam int unsigned GAP_W   = 4;
  localparam int unsigned NPLAYER = 4;

  localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(STEP_GAP - 1);
  localparam logic [POS_W:0]   TRACK_EXT = (POS_W + 1)'(TRACK);
  localparam logic [POS_W-1:0] POS_LAST  = POS_W'(TRACK - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PULSE = 2'd1,
    S_GAP   = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [PID_W-1:0]    pid_q, pid_d;
  logic [STEP_W-1:0]   rem_q, rem_d;
  logic [GAP_W-1:0]    gap_q, gap_d;
  logic [POS_W-1:0]    shadow_q [NPLAYER];
  logic [POS_W-1:0]    shadow_d [NPLAYER];
  logic                strobe_q, strobe_d;
  logic [NPLAYER-1:0]  p_da_q, p_da_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [POS_W-1:0]    cur_pos_q, cur_pos_d;
  logic                accept_c;

  // State register and all registered datapath/outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      pid_q     <= '0;
      rem_q     <= '0;
      gap_q     <= '0;
      strobe_q  <= 1'b0;
      p_da_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      cur_pos_q <= '0;
      for (int i = 0; i < NPLAYER; i++) begin
        shadow_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      pid_q     <= pid_d;
      rem_q     <= rem_d;
      gap_q     <= gap_d;
      strobe_q  <= strobe_d;
      p_da_q    <= p_da_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      cur_pos_q <= cur_pos_d;
      for (int i = 0; i < NPLAYER; i++) begin
        shadow_q[i] <= shadow_d[i];
      end
    end
  end

  // Next-state logic; setup overrides every state and blocks new moves
  always_comb begin
    state_d  = state_q;
    accept_c = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start && !setup) begin
          accept_c = 1'b1;
          state_d  = (steps != '0) ? S_PULSE : S_DONE;
        end
      end
      S_PULSE: state_d = S_GAP;
      S_GAP: begin
        if (gap_q == '0) begin
          state_d = (rem_q != '0) ? S_PULSE : S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (setup) begin
      state_d = S_IDLE;
    end
  end

  // Datapath: outputs are computed from the next state so they line up with it
  always_comb begin
    pid_d = accept_c ? pid : pid_q;

    rem_d = accept_c ? steps : rem_q;
    if (state_d == S_PULSE) begin
      rem_d = rem_d - STEP_W'(1);
    end

    gap_d = gap_q;
    if (state_d == S_GAP) begin
      gap_d = (state_q == S_GAP) ? gap_q - GAP_W'(1) : GAP_LAST;
    end

    for (int i = 0; i < NPLAYER; i++) begin
      shadow_d[i] = shadow_q[i];
    end
    if (setup && setup_we) begin
      shadow_d[setup_pid] = ({1'b0, setup_pos} < TRACK_EXT) ? setup_pos : '0;
    end
    // Each pulse advances the active player's square, wrapping at the track end
    if (state_d == S_PULSE) begin
      shadow_d[pid_d] = (shadow_q[pid_d] == POS_LAST) ? '0
                                                      : shadow_q[pid_d] + POS_W'(1);
    end

    strobe_d  = (state_d == S_PULSE);
    busy_d    = (state_d != S_IDLE);
    done_d    = (state_d == S_DONE);
    p_da_d    = busy_d ? (NPLAYER'(1) << pid_d) : '0;
    cur_pos_d = shadow_d[pid_d];
  end

  assign D       = strobe_q;
  assign p_da    = p_da_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign cur_pos = cur_pos_q;

endmodule

// File: tb/tb_move_stepper.sv
// Randomized self-checking bench for move_stepper against a schedule/position model.
module tb_move_stepper;

  localparam int TRACK = 24;
  localparam int G     = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       setup, setup_we;
  logic [1:0] setup_pid;
  logic [4:0] setup_pos;
  logic       start;
  logic [1:0] pid;
  logic [2:0] steps;
  logic       D;
  logic [3:0] p_da;
  logic       busy, done;
  logic [4:0] cur_pos;

  int checks = 0;
  int errors = 0;
  int shadow_m [4];
  int last_pid_m;

  move_stepper #(.TRACK(TRACK), .STEP_GAP(G)) dut (
    .clk(clk), .rst(rst), .setup(setup), .setup_we(setup_we),
    .setup_pid(setup_pid), .setup_pos(setup_pos), .start(start),
    .pid(pid), .steps(steps), .D(D), .p_da(p_da), .busy(busy),
    .done(done), .cur_pos(cur_pos)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_idle(input string tag);
    check_val({tag, " D"}, int'(D), 0);
    check_val({tag, " p_da"}, int'(p_da), 0);
    check_val({tag, " busy"}, int'(busy), 0);
    check_val({tag, " done"}, int'(done), 0);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) shadow_m[i] = 0;
    last_pid_m = 0;
  endtask

  // Load a shadow position through setup mode
  task automatic setup_write(input int p, input int v);
    @(negedge clk);
    setup = 1'b1; setup_we = 1'b1; setup_pid = 2'(p); setup_pos = 5'(v);
    @(negedge clk);
    setup = 1'b0; setup_we = 1'b0;
    shadow_m[p] = (v < TRACK) ? v : 0;
    check_idle("setup");
    check_val("setup cur_pos", int'(cur_pos), shadow_m[last_pid_m]);
  endtask

  // One move; abort_at>0 raises setup in that cycle; hammer keeps start high with noisy pid/steps
  task automatic do_move(input int p, input int n, input int abort_at, input bit hammer);
    int done_c, base, pulses, k;
    bit exp_d, aborted;
    done_c  = (n == 0) ? 1 : 1 + (n - 1) * (G + 1) + G + 1;
    base    = shadow_m[p];
    pulses  = 0;
    aborted = 1'b0;
    @(negedge clk);
    start = 1'b1; pid = 2'(p); steps = 3'(n);
    last_pid_m = p;
    @(posedge clk);
    for (int c = 1; c <= done_c; c++) begin
      @(negedge clk);
      k     = (c - 1) / (G + 1);
      exp_d = (n > 0) && ((c - 1) % (G + 1) == 0) && (k < n);
      if (exp_d) pulses++;
      check_val("move D", int'(D), int'(exp_d));
      check_val("move done", int'(done), int'(c == done_c));
      check_val("move busy", int'(busy), 1);
      check_val("move p_da", int'(p_da), 1 << p);
      check_val("move cur_pos", int'(cur_pos), (base + pulses) % TRACK);
      if (hammer) begin
        pid = 2'($urandom); steps = 3'($urandom);
      end else begin
        start = 1'b0;
      end
      if (c == abort_at) begin
        setup = 1'b1; start = 1'b0; aborted = 1'b1;
        break;
      end
      if (c == done_c) start = 1'b0;
    end
    shadow_m[p] = (base + pulses) % TRACK;
    @(negedge clk);
    check_idle(aborted ? "abort" : "after");
    check_val("after cur_pos", int'(cur_pos), shadow_m[p]);
    setup = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout");
    $fatal(1, "bench timeout");
  end

  initial begin
    int r, p, n, dc, ab;
    rst = 1'b1; setup = 1'b0; setup_we = 1'b0; setup_pid = '0; setup_pos = '0;
    start = 1'b0; pid = '0; steps = '0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_idle("reset");
    check_val("reset cur_pos", int'(cur_pos), 0);
    rst = 1'b0;

    do_move(2, 3, 0, 1'b0);
    check_val("dir1 pos", shadow_m[2], 3);
    setup_write(1, 22);
    do_move(1, 3, 0, 1'b0);
    do_move(0, 0, 0, 1'b0);
    do_move(3, 2, 0, 1'b1);
    do_move(0, 5, 2, 1'b0);
    setup_write(0, 30);
    setup_write(1, 23);
    do_move(1, 7, 0, 1'b1);

    // Asynchronous reset in the middle of a pulse
    @(negedge clk);
    start = 1'b1; pid = 2'd3; steps = 3'd4;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    check_val("pre-rst D", int'(D), 1);
    #1 rst = 1'b1;
    #1;
    check_val("async D", int'(D), 0);
    check_val("async p_da", int'(p_da), 0);
    check_val("async busy", int'(busy), 0);
    check_val("async cur_pos", int'(cur_pos), 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 4; i++) do_move(i, 0, 0, 1'b0);

    for (int it = 0; it < 40; it++) begin
      r = $urandom_range(0, 9);
      p = $urandom_range(0, 3);
      n = $urandom_range(0, 7);
      if (r < 2) begin
        setup_write(p, $urandom_range(0, 31));
      end else begin
        ab = 0;
        if (r == 2 && n > 0) begin
          dc = 1 + (n - 1) * (G + 1) + G + 1;
          ab = $urandom_range(1, dc - 1);
        end
        do_move(p, n, ab, 1'($urandom_range(0, 1)));
      end
    end
    for (int i = 0; i < 4; i++) do_move(i, 0, 0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
